// File: rtl/alarm_zone_controller.sv
// Multi-zone timed alarm controller: exit/entry delays, instant zones, timed siren,
// latched zone memory with acknowledge. All status outputs are decoded from registers.
module alarm_zone_controller #(
    parameter int unsigned          NZONES       = 4,
    parameter int unsigned          EXIT_DELAY   = 10,
    parameter int unsigned          ENTRY_DELAY  = 5,
    parameter int unsigned          SIREN_TIME   = 20,
    parameter logic [NZONES-1:0]    INSTANT_MASK = NZONES'(1),
    localparam int unsigned         MAX_T        = (EXIT_DELAY > ENTRY_DELAY)
                                                   ? ((EXIT_DELAY > SIREN_TIME) ? EXIT_DELAY : SIREN_TIME)
                                                   : ((ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME),
    localparam int unsigned         CNT_W        = $clog2(MAX_T + 1)
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic [NZONES-1:0] zone_open,
    input  logic [NZONES-1:0] zone_en,
    input  logic              day,
    input  logic              force_arm,
    input  logic              ack,
    output logic              siren,
    output logic              armed,
    output logic [2:0]        state,
    output logic [NZONES-1:0] zone_latched,
    output logic [CNT_W-1:0]  countdown
);

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4,
        SILENT   = 3'd5
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NZONES-1:0]   r_latched;
    logic [NZONES-1:0]   r_zone_s1, r_zone_s2;
    logic                r_day_s1, r_day_s2;
    logic                r_farm_s1, r_farm_s2;
    logic                r_ack_s1, r_ack_s2, r_ack_d;

    logic                w_arm_cond;
    logic                w_ack_p;
    logic [NZONES-1:0]   w_trig;
    logic                w_instant;
    logic                w_any_trig;
    logic                w_latch_st;
    logic                w_cnt_zero;

    assign w_arm_cond = r_farm_s2 | ~r_day_s2;
    assign w_ack_p    = r_ack_s2 & ~r_ack_d;
    assign w_trig     = r_zone_s2 & zone_en;
    assign w_instant  = |(w_trig & INSTANT_MASK);
    assign w_any_trig = |w_trig;
    assign w_latch_st = (r_state == ARMED) || (r_state == ENTRY) || (r_state == ALARM);
    assign w_cnt_zero = (r_cnt == '0);

    // Synchronizers, zone memory and the alarm state machine
    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            r_state   <= DISARMED;
            r_cnt     <= '0;
            r_latched <= '0;
            r_zone_s1 <= '0;
            r_zone_s2 <= '0;
            r_day_s1  <= 1'b0;
            r_day_s2  <= 1'b0;
            r_farm_s1 <= 1'b0;
            r_farm_s2 <= 1'b0;
            r_ack_s1  <= 1'b0;
            r_ack_s2  <= 1'b0;
            r_ack_d   <= 1'b0;
        end else begin
            r_zone_s1 <= zone_open;
            r_zone_s2 <= r_zone_s1;
            r_day_s1  <= day;
            r_day_s2  <= r_day_s1;
            r_farm_s1 <= force_arm;
            r_farm_s2 <= r_farm_s1;
            r_ack_s1  <= ack;
            r_ack_s2  <= r_ack_s1;
            r_ack_d   <= r_ack_s2;

            // ack clears memory in any state; live triggers are folded back in
            r_latched <= (w_ack_p ? '0 : r_latched)
                       | ((w_arm_cond && w_latch_st) ? w_trig : '0);

            if (!w_arm_cond) begin
                r_state <= DISARMED;
                r_cnt   <= '0;
            end else if (w_ack_p && (r_state == ALARM || r_state == SILENT)) begin
                r_state <= ARMED;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    DISARMED: begin
                        r_state <= EXIT;
                        r_cnt   <= CNT_W'(EXIT_DELAY - 1);
                    end
                    EXIT: begin
                        if (w_cnt_zero) r_state <= ARMED;
                        else            r_cnt   <= r_cnt - CNT_W'(1);
                    end
                    ARMED: begin
                        if (w_instant) begin
                            r_state <= ALARM;
                            r_cnt   <= CNT_W'(SIREN_TIME - 1);
                        end else if (w_any_trig) begin
                            r_state <= ENTRY;
                            r_cnt   <= CNT_W'(ENTRY_DELAY - 1);
                        end
                    end
                    ENTRY: begin
                        if (w_instant || w_cnt_zero) begin
                            r_state <= ALARM;
                            r_cnt   <= CNT_W'(SIREN_TIME - 1);
                        end else begin
                            r_cnt   <= r_cnt - CNT_W'(1);
                        end
                    end
                    ALARM: begin
                        if (w_cnt_zero) r_state <= SILENT;
                        else            r_cnt   <= r_cnt - CNT_W'(1);
                    end
                    SILENT: begin
                        r_state <= SILENT;
                    end
                    default: begin
                        r_state <= DISARMED;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign state        = r_state;
    assign siren        = (r_state == ALARM);
    assign armed        = (r_state == ARMED) || (r_state == ENTRY)
                       || (r_state == ALARM) || (r_state == SILENT);
    assign zone_latched = r_latched;
    assign countdown    = (r_state == EXIT || r_state == ENTRY || r_state == ALARM) ? r_cnt : '0;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Scoreboard bench for alarm_zone_controller: directed stimulus queues expected
// status per clock edge, a monitor pops and compares after each edge.
module tb_alarm_zone_controller;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [3:0] zone_open;
    logic [3:0] zone_en;
    logic       day;
    logic       force_arm;
    logic       ack;
    logic       siren;
    logic       armed;
    logic [2:0] state;
    logic [3:0] zone_latched;
    logic [4:0] countdown;

    alarm_zone_controller dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .zone_open    (zone_open),
        .zone_en      (zone_en),
        .day          (day),
        .force_arm    (force_arm),
        .ack          (ack),
        .siren        (siren),
        .armed        (armed),
        .state        (state),
        .zone_latched (zone_latched),
        .countdown    (countdown)
    );

    always #5 clk_2 = ~clk_2;

    int          edge_cnt = 0;
    int          n_chk    = 0;
    int          n_err    = 0;
    int          q_e[$];
    string       q_nm[$];
    logic [13:0] q_v[$];

    function automatic logic [13:0] mk(input logic [2:0] st, input logic [3:0] lat, input logic [4:0] cd);
        logic sir;
        logic arm;
        sir = (st == 3'd4);
        arm = (st >= 3'd2) && (st <= 3'd5);
        return {st, sir, arm, lat, cd};
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got state=%0d siren=%b armed=%b latched=%b countdown=%0d, expected state=%0d siren=%b armed=%b latched=%b countdown=%0d",
                     nm, act[13:11], act[10], act[9], act[8:5], act[4:0],
                     exp_v[13:11], exp_v[10], exp_v[9], exp_v[8:5], exp_v[4:0]);
        end
    endtask

    // Queue the expected status k edges from now
    task automatic exp_at(input int k, input string nm, input logic [2:0] st,
                          input logic [3:0] lat, input logic [4:0] cd);
        q_e.push_back(edge_cnt + k);
        q_nm.push_back(nm);
        q_v.push_back(mk(st, lat, cd));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_2);
    endtask

    // Synchronizers come out of reset at 0 (night), so a short EXIT blip precedes DISARMED
    task automatic post_reset_expect();
        exp_at(1, "rst_blip1", 3'd1, 4'b0000, 5'd9);
        exp_at(2, "rst_blip2", 3'd1, 4'b0000, 5'd8);
        exp_at(3, "rst_idle",  3'd0, 4'b0000, 5'd0);
        tick(4);
    endtask

    logic [13:0] mon_v;
    string       mon_nm;
    int          mon_e;

    always begin
        @(posedge clk_2);
        #1;
        edge_cnt++;
        while (q_e.size() > 0 && q_e[0] <= edge_cnt) begin
            mon_e  = q_e.pop_front();
            mon_nm = q_nm.pop_front();
            mon_v  = q_v.pop_front();
            chk(mon_nm, {state, siren, armed, zone_latched, countdown}, mon_v);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; day = 1'b1; force_arm = 1'b0; ack = 1'b0;
        zone_open = 4'b0000; zone_en = 4'b1111;
        tick(2);
        chk("reset_state", {state, siren, armed, zone_latched, countdown}, mk(3'd0, 4'b0000, 5'd0));
        reset = 1'b1;
        post_reset_expect();

        // Night arms: EXIT at edge 3, ARMED at edge 13
        day = 1'b0;
        exp_at(1,  "t1_e1",    3'd0, 4'b0000, 5'd0);
        exp_at(2,  "t1_e2",    3'd0, 4'b0000, 5'd0);
        exp_at(3,  "t1_exit",  3'd1, 4'b0000, 5'd9);
        exp_at(12, "t1_cd0",   3'd1, 4'b0000, 5'd0);
        exp_at(13, "t1_armed", 3'd2, 4'b0000, 5'd0);
        tick(13);

        // Delayed zone 2: ENTRY, ALARM, SILENT
        zone_open = 4'b0100;
        exp_at(2,  "t2_armed",     3'd2, 4'b0000, 5'd0);
        exp_at(3,  "t2_entry",     3'd3, 4'b0100, 5'd4);
        exp_at(7,  "t2_entry_cd0", 3'd3, 4'b0100, 5'd0);
        exp_at(8,  "t2_alarm",     3'd4, 4'b0100, 5'd19);
        exp_at(27, "t2_alarm_end", 3'd4, 4'b0100, 5'd0);
        exp_at(28, "t2_silent",    3'd5, 4'b0100, 5'd0);
        tick(28);
        exp_at(5, "t2_silent_hold", 3'd5, 4'b0100, 5'd0);
        tick(5);
        zone_open = 4'b0000; ack = 1'b1;
        exp_at(2, "t2_ack_wait", 3'd5, 4'b0100, 5'd0);
        exp_at(3, "t2_ack",      3'd2, 4'b0000, 5'd0);
        tick(3);
        ack = 1'b0;
        exp_at(3, "t2_after_ack", 3'd2, 4'b0000, 5'd0);
        tick(3);

        // Instant zone 0, then ack with zone still open re-enters ALARM
        zone_open = 4'b0001;
        exp_at(2, "t3_armed", 3'd2, 4'b0000, 5'd0);
        exp_at(3, "t3_alarm", 3'd4, 4'b0001, 5'd19);
        tick(3);
        ack = 1'b1;
        exp_at(2, "t3_alarm_cd",    3'd4, 4'b0001, 5'd17);
        exp_at(3, "t3_ack_armed",   3'd2, 4'b0001, 5'd0);
        exp_at(4, "t3_rearm_alarm", 3'd4, 4'b0001, 5'd19);
        tick(4);
        ack = 1'b0; zone_open = 4'b0000; day = 1'b1;
        exp_at(2, "t3_pre_disarm", 3'd4, 4'b0001, 5'd17);
        exp_at(3, "t3_disarm",     3'd0, 4'b0001, 5'd0);
        tick(3);

        // Disarm during ENTRY at countdown 2: siren never asserts, memory kept
        day = 1'b0;
        exp_at(3,  "t4_exit",  3'd1, 4'b0001, 5'd9);
        exp_at(13, "t4_armed", 3'd2, 4'b0001, 5'd0);
        tick(13);
        zone_open = 4'b0100;
        exp_at(3, "t4_entry",     3'd3, 4'b0101, 5'd4);
        exp_at(5, "t4_entry_cd2", 3'd3, 4'b0101, 5'd2);
        tick(5);
        day = 1'b1; zone_open = 4'b0000;
        exp_at(2, "t4_entry_cd0",     3'd3, 4'b0101, 5'd0);
        exp_at(3, "t4_disarm",        3'd0, 4'b0101, 5'd0);
        exp_at(8, "t4_stay_disarmed", 3'd0, 4'b0101, 5'd0);
        tick(8);
        ack = 1'b1;
        exp_at(2, "t4_ack_wait",  3'd0, 4'b0101, 5'd0);
        exp_at(3, "t4_ack_clear", 3'd0, 4'b0000, 5'd0);
        tick(3);
        ack = 1'b0;
        tick(2);

        // Disabled zone and zones opened during EXIT are ignored
        zone_en = 4'b1101; day = 1'b0; zone_open = 4'b1111;
        exp_at(3, "t5_exit", 3'd1, 4'b0000, 5'd9);
        tick(10);
        zone_open = 4'b0010;
        exp_at(2, "t5_exit_end",    3'd1, 4'b0000, 5'd0);
        exp_at(3, "t5_armed",       3'd2, 4'b0000, 5'd0);
        exp_at(8, "t5_still_armed", 3'd2, 4'b0000, 5'd0);
        tick(8);

        // Disarm and trigger on the same edge: disarm wins
        zone_open = 4'b0110; day = 1'b1;
        exp_at(2, "t6_armed",       3'd2, 4'b0000, 5'd0);
        exp_at(3, "t6_disarm_wins", 3'd0, 4'b0000, 5'd0);
        tick(4);
        zone_open = 4'b0000; zone_en = 4'b1111;
        tick(1);
        force_arm = 1'b1;
        exp_at(3, "t6_force_exit", 3'd1, 4'b0000, 5'd9);
        tick(4);
        force_arm = 1'b0;
        exp_at(3, "t6_force_off", 3'd0, 4'b0000, 5'd0);
        tick(3);

        // Reset pulse mid-ALARM
        day = 1'b0;
        exp_at(13, "t6_armed2", 3'd2, 4'b0000, 5'd0);
        tick(13);
        zone_open = 4'b0001;
        exp_at(3, "t6_alarm",    3'd4, 4'b0001, 5'd19);
        exp_at(5, "t6_alarm_cd", 3'd4, 4'b0001, 5'd17);
        tick(5);
        #2;
        reset = 1'b0; day = 1'b1; zone_open = 4'b0000;
        #1;
        chk("t6_reset_async", {state, siren, armed, zone_latched, countdown}, mk(3'd0, 4'b0000, 5'd0));
        exp_at(1, "t6_reset_held", 3'd0, 4'b0000, 5'd0);
        @(negedge clk_2);
        reset = 1'b1;
        post_reset_expect();

        tick(2);
        while (q_e.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: got no check at edge %0d, expected one", q_nm[0], q_e[0]);
            void'(q_e.pop_front());
            void'(q_nm.pop_front());
            void'(q_v.pop_front());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
